// File: rtl/pmp_pkg.sv
// Shared encodings for the sequential PMP checker: privilege levels, access types,
// pmpcfg field positions, address-matching modes and the walk FSM states.
package pmp_pkg;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [2:0] ACC_READ  = 3'b001;
    localparam logic [2:0] ACC_WRITE = 3'b010;
    localparam logic [2:0] ACC_EXEC  = 3'b100;

    localparam int unsigned CFG_R    = 0;
    localparam int unsigned CFG_W    = 1;
    localparam int unsigned CFG_X    = 2;
    localparam int unsigned CFG_A_LO = 3;
    localparam int unsigned CFG_A_HI = 4;
    localparam int unsigned CFG_L    = 7;

    typedef enum logic [1:0] {
        A_OFF   = 2'b00,
        A_TOR   = 2'b01,
        A_NA4   = 2'b10,
        A_NAPOT = 2'b11
    } pmp_a_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WALK = 2'b01,
        RESP = 2'b10
    } walk_state_e;

endpackage

// File: rtl/pmp_entry_match.sv
// Address match for a single PMP entry; addresses are word addresses (byte addr >> 2).
module pmp_entry_match
    import pmp_pkg::*;
#(
    parameter int unsigned PMP_LEN = 54
) (
    input  logic [PMP_LEN-1:0] addr_i,
    input  logic [7:0]         cfg_i,
    input  logic [PMP_LEN-1:0] pmpaddr_i,
    input  logic [PMP_LEN-1:0] prev_pmpaddr_i,
    input  logic               is_first_i,
    output logic               match_o
);

    pmp_a_e             mode;
    logic [PMP_LEN-1:0] tor_lo;
    logic [PMP_LEN-1:0] napot_mask;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        mode       = pmp_a_e'(cfg_i[CFG_A_HI:CFG_A_LO]);
        tor_lo     = is_first_i ? '0 : prev_pmpaddr_i;
        // x ^ (x+1) sets bits [t:0] for t trailing ones; all-ones pmpaddr yields an all-ones mask.
        napot_mask = pmpaddr_i ^ (pmpaddr_i + PMP_LEN'(1));
        match_o    = 1'b0;
        case (mode)
            A_TOR:   match_o = (addr_i >= tor_lo) && (addr_i < pmpaddr_i);
            A_NA4:   match_o = (addr_i == pmpaddr_i);
            A_NAPOT: match_o = ((addr_i ^ pmpaddr_i) & ~napot_mask) == '0;
            default: match_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pmp_seq_checker.sv
// Sequential PMP responder: walks one entry per cycle in priority order, stops at the
// first match and returns allow/match/index over a valid/ready response handshake.
module pmp_seq_checker
    import pmp_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [PLEN-1:0]                 addr_i,
    input  logic [2:0]                      access_type_i,
    input  logic [1:0]                      priv_lvl_i,
    input  logic [NR_ENTRIES*8-1:0]         conf_i,
    input  logic [NR_ENTRIES*PMP_LEN-1:0]   conf_addr_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic                            allow_o,
    output logic                            match_o,
    output logic [3:0]                      match_idx_o
);

    localparam int unsigned CTR_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    walk_state_e        state_q;
    logic [CTR_W-1:0]   ctr_q;
    logic [PMP_LEN-1:0] addr_q;
    logic [2:0]         type_q;
    logic [1:0]         priv_q;
    logic               rsp_valid_q;
    logic               allow_q;
    logic               match_q;
    logic [3:0]         match_idx_q;

    int                 cur_idx;
    int                 prv_idx;
    logic [7:0]         cur_cfg;
    logic [PMP_LEN-1:0] cur_pmpaddr;
    logic [PMP_LEN-1:0] prv_pmpaddr;
    logic [2:0]         perm;
    logic               entry_match;
    logic               entry_allow;
    logic               last_entry;

    always_comb begin
        cur_idx     = int'(ctr_q);
        prv_idx     = (ctr_q == '0) ? 0 : cur_idx - 1;
        cur_cfg     = conf_i[cur_idx*8 +: 8];
        cur_pmpaddr = conf_addr_i[cur_idx*PMP_LEN +: PMP_LEN];
        prv_pmpaddr = conf_addr_i[prv_idx*PMP_LEN +: PMP_LEN];
        // W without R is reserved and behaves as W=0.
        perm        = {cur_cfg[CFG_X], cur_cfg[CFG_W] & cur_cfg[CFG_R], cur_cfg[CFG_R]};
        entry_allow = ((priv_q == PRIV_M) && !cur_cfg[CFG_L]) ? 1'b1 : |(type_q & perm);
        last_entry  = (ctr_q == CTR_W'(NR_ENTRIES - 1));
    end

    pmp_entry_match #(
        .PMP_LEN (PMP_LEN)
    ) u_entry_match (
        .addr_i         (addr_q),
        .cfg_i          (cur_cfg),
        .pmpaddr_i      (cur_pmpaddr),
        .prev_pmpaddr_i (prv_pmpaddr),
        .is_first_i     (ctr_q == '0),
        .match_o        (entry_match)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            addr_q      <= '0;
            type_q      <= '0;
            priv_q      <= PRIV_U;
            rsp_valid_q <= 1'b0;
            allow_q     <= 1'b0;
            match_q     <= 1'b0;
            match_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q <= addr_i[PLEN-1:2];
                        type_q <= access_type_i;
                        priv_q <= priv_lvl_i;
                        ctr_q  <= '0;
                        if ($onehot(access_type_i)) begin
                            state_q <= WALK;
                        end else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            allow_q     <= 1'b0;
                            match_q     <= 1'b0;
                            match_idx_q <= '0;
                        end
                    end
                end
                WALK: begin
                    if (entry_match) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        allow_q     <= entry_allow;
                        match_q     <= 1'b1;
                        match_idx_q <= 4'(ctr_q);
                    end else if (last_entry) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        allow_q     <= (priv_q == PRIV_M);
                        match_q     <= 1'b0;
                        match_idx_q <= '0;
                    end else begin
                        ctr_q <= ctr_q + CTR_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign allow_o     = allow_q;
    assign match_o     = match_q;
    assign match_idx_o = match_idx_q;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Self-checking bench for pmp_seq_checker: directed scenarios plus randomized traffic
// compared against a first-match PMP reference model.
module tb_pmp_seq_checker;

    localparam int N  = 16;
    localparam int PL = 56;
    localparam int AL = 54;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_valid_i = 1'b0;
    logic              req_ready_o;
    logic [PL-1:0]     addr_i = '0;
    logic [2:0]        access_type_i = 3'b001;
    logic [1:0]        priv_lvl_i = 2'b00;
    logic [N*8-1:0]    conf_i = '0;
    logic [N*AL-1:0]   conf_addr_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic              allow_o;
    logic              match_o;
    logic [3:0]        match_idx_o;

    logic [7:0]        cfg   [N];
    logic [AL-1:0]     paddr [N];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    pmp_seq_checker dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .addr_i        (addr_i),
        .access_type_i (access_type_i),
        .priv_lvl_i    (priv_lvl_i),
        .conf_i        (conf_i),
        .conf_addr_i   (conf_addr_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .allow_o       (allow_o),
        .match_o       (match_o),
        .match_idx_o   (match_idx_o)
    );

    // Reference: first matching entry wins; latency counts entries examined plus one.
    function automatic void model(input logic [PL-1:0] a, input logic [2:0] t, input logic [1:0] p,
                                  output int lat, output logic al, output logic m, output logic [3:0] ix);
        logic [AL-1:0] wa;
        logic [AL-1:0] lo;
        logic [1:0]    mode;
        logic          hit;
        logic          r;
        int            tt;
        wa  = a[PL-1:2];
        lat = 1; al = 1'b0; m = 1'b0; ix = 4'd0;
        if (!(t == 3'b001 || t == 3'b010 || t == 3'b100)) return;
        for (int i = 0; i < N; i++) begin
            mode = cfg[i][4:3];
            hit  = 1'b0;
            lo   = '0;
            if (i > 0) lo = paddr[i-1];
            if (mode == 2'b01) hit = (wa >= lo) && (wa < paddr[i]);
            else if (mode == 2'b10) hit = (wa == paddr[i]);
            else if (mode == 2'b11) begin
                tt = 0;
                while (tt < AL && paddr[i][tt]) tt++;
                hit = (tt >= AL - 1) || ((wa >> (tt + 1)) == (paddr[i] >> (tt + 1)));
            end
            if (hit) begin
                lat = i + 2; m = 1'b1; ix = 4'(i);
                r = cfg[i][0];
                if (p == 2'b11 && !cfg[i][7]) al = 1'b1;
                else al = (t == 3'b001 && r) || (t == 3'b010 && r && cfg[i][1]) || (t == 3'b100 && cfg[i][2]);
                return;
            end
        end
        lat = N + 1;
        al  = (p == 2'b11);
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) begin
            cfg[i] = 8'h00; paddr[i] = '0;
        end
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < N; i++) begin
            conf_i[i*8 +: 8]       = cfg[i];
            conf_addr_i[i*AL +: AL] = paddr[i];
        end
    endtask

    // Issue one request and collect the response; lat counts cycles from the accept cycle.
    task automatic do_req(input logic [PL-1:0] a, input logic [2:0] t, input logic [1:0] p,
                          output int lat, output logic al, output logic m, output logic [3:0] ix);
        int budget;
        @(negedge clk_i);
        budget = 0;
        while (!req_ready_o && budget < 40) begin @(negedge clk_i); budget++; end
        req_valid_i = 1'b1; addr_i = a; access_type_i = t; priv_lvl_i = p;
        @(posedge clk_i);
        lat = 1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        while (!rsp_valid_o && lat < 40) begin @(negedge clk_i); lat++; end
        al = allow_o; m = match_o; ix = match_idx_o;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    task automatic run_and_compare(input string name, input logic [PL-1:0] a, input logic [2:0] t, input logic [1:0] p);
        int e_lat, o_lat;
        logic e_al, o_al, e_m, o_m;
        logic [3:0] e_ix, o_ix;
        model(a, t, p, e_lat, e_al, e_m, e_ix);
        do_req(a, t, p, o_lat, o_al, o_m, o_ix);
        checks++;
        if (o_lat !== e_lat) begin errors++; $display("FAIL %s latency: got %0d exp %0d", name, o_lat, e_lat); end
        checks++;
        if (o_al !== e_al) begin errors++; $display("FAIL %s allow: got %0b exp %0b (addr %h)", name, o_al, e_al, a); end
        checks++;
        if (o_m !== e_m) begin errors++; $display("FAIL %s match: got %0b exp %0b (addr %h)", name, o_m, e_m, a); end
        checks++;
        if (o_ix !== e_ix) begin errors++; $display("FAIL %s idx: got %0d exp %0d (addr %h)", name, o_ix, e_ix, a); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({req_ready_o, rsp_valid_o, allow_o, match_o, match_idx_o} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset: got rdy=%0b vld=%0b al=%0b m=%0b ix=%0d exp 1 0 0 0 0",
                     req_ready_o, rsp_valid_o, allow_o, match_o, match_idx_o);
        end
    endtask

    task automatic test_all_off();
        clear_cfg(); apply_cfg();
        run_and_compare("off_u_read", 56'h8000_0000, 3'b001, 2'b00);
        run_and_compare("off_m_read", 56'h8000_0000, 3'b001, 2'b11);
    endtask

    task automatic test_napot();
        clear_cfg();
        paddr[3] = 54'h2000_01FF; cfg[3] = 8'h19;
        apply_cfg();
        run_and_compare("napot_read_in",  56'h8000_0FFC, 3'b001, 2'b00);
        run_and_compare("napot_write_in", 56'h8000_0FFC, 3'b010, 2'b00);
        run_and_compare("napot_read_out", 56'h8000_1000, 3'b001, 2'b00);
        run_and_compare("napot_read_lo",  56'h8000_0000, 3'b001, 2'b01);
    endtask

    task automatic test_priority();
        clear_cfg();
        paddr[0] = 54'h400; cfg[0] = 8'h09;
        paddr[1] = 54'h800; cfg[1] = 8'h0B;
        paddr[2] = 54'h7FF; cfg[2] = 8'h19;
        apply_cfg();
        run_and_compare("prio_tor_write",  56'h1800, 3'b010, 2'b00);
        run_and_compare("prio_tor0_read",  56'h0,    3'b001, 2'b00);
        run_and_compare("prio_napot_wr",   56'h2800, 3'b010, 2'b00);
        run_and_compare("prio_tor_top",    56'h1FFC, 3'b001, 2'b00);
    endtask

    task automatic test_lock();
        clear_cfg();
        paddr[0] = 54'h10; cfg[0] = 8'h91;
        apply_cfg();
        run_and_compare("lock_m_write", 56'h40, 3'b010, 2'b11);
        run_and_compare("lock_m_read",  56'h40, 3'b001, 2'b11);
        cfg[0] = 8'h11; apply_cfg();
        run_and_compare("unlock_m_write", 56'h40, 3'b010, 2'b11);
        cfg[0] = 8'h12; apply_cfg();
        run_and_compare("w_no_r_write", 56'h40, 3'b010, 2'b00);
        run_and_compare("bad_type_011", 56'h40, 3'b011, 2'b11);
        run_and_compare("bad_type_000", 56'h40, 3'b000, 2'b11);
    endtask

    task automatic test_back_to_back();
        int e_lat, budget;
        logic e_al, e_m, s_al, s_m;
        logic [3:0] e_ix, s_ix;
        clear_cfg();
        paddr[3] = 54'h2000_01FF; cfg[3] = 8'h19;
        apply_cfg();
        @(negedge clk_i);
        req_valid_i = 1'b1; addr_i = 56'h8000_0FFC; access_type_i = 3'b001; priv_lvl_i = 2'b00;
        @(posedge clk_i);
        @(negedge clk_i);
        addr_i = 56'h8000_1000;
        budget = 0;
        while (!rsp_valid_o && budget < 40) begin @(negedge clk_i); budget++; end
        s_al = allow_o; s_m = match_o; s_ix = match_idx_o;
        model(56'h8000_0FFC, 3'b001, 2'b00, e_lat, e_al, e_m, e_ix);
        checks++;
        if ({s_al, s_m, s_ix} !== {e_al, e_m, e_ix}) begin
            errors++; $display("FAIL bp_first: got %b exp %b", {s_al, s_m, s_ix}, {e_al, e_m, e_ix});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            checks++;
            if ({rsp_valid_o, req_ready_o, allow_o, match_o, match_idx_o} !== {1'b1, 1'b0, s_al, s_m, s_ix}) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got vld=%0b rdy=%0b al=%0b m=%0b ix=%0d", c,
                         rsp_valid_o, req_ready_o, allow_o, match_o, match_idx_o);
            end
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        checks++;
        if ({rsp_valid_o, req_ready_o} !== 2'b01) begin
            errors++; $display("FAIL bp_release: got vld=%0b rdy=%0b exp 0 1", rsp_valid_o, req_ready_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        budget = 0;
        while (!rsp_valid_o && budget < 40) begin @(negedge clk_i); budget++; end
        model(56'h8000_1000, 3'b001, 2'b00, e_lat, e_al, e_m, e_ix);
        checks++;
        if ({rsp_valid_o, allow_o, match_o, match_idx_o} !== {1'b1, e_al, e_m, e_ix}) begin
            errors++;
            $display("FAIL bp_second: got vld=%0b al=%0b m=%0b ix=%0d exp 1 %0b %0b %0d",
                     rsp_valid_o, allow_o, match_o, match_idx_o, e_al, e_m, e_ix);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_walk();
        int seen;
        clear_cfg(); apply_cfg();
        @(negedge clk_i);
        req_valid_i = 1'b1; addr_i = 56'h8000_0000; access_type_i = 3'b001; priv_lvl_i = 2'b00;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, rsp_valid_o, allow_o, match_o, match_idx_o} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL mid_walk_reset: got rdy=%0b vld=%0b al=%0b m=%0b ix=%0d exp 1 0 0 0 0",
                     req_ready_o, rsp_valid_o, allow_o, match_o, match_idx_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        repeat (20) begin @(negedge clk_i); if (rsp_valid_o) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_walk_no_rsp: got %0d valid cycles exp 0", seen); end
    endtask

    task automatic test_random();
        logic [AL-1:0] wa;
        logic [2:0]    t;
        logic [1:0]    p;
        int            e;
        for (int n = 0; n < 60; n++) begin
            if (n % 10 == 0) begin
                for (int i = 0; i < N; i++) begin
                    cfg[i]   = 8'($urandom_range(0, 255)) & 8'h9F;
                    paddr[i] = AL'($urandom_range(0, 4095));
                    if ($urandom_range(0, 2) == 0) paddr[i] = paddr[i] | AL'((1 << $urandom_range(0, 6)) - 1);
                end
                @(negedge clk_i);
                apply_cfg();
            end
            e  = $urandom_range(0, N - 1);
            wa = paddr[e] + AL'($urandom_range(0, 8)) - AL'(4);
            if ($urandom_range(0, 3) == 0) wa = AL'($urandom_range(0, 4095));
            t = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) t = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0: p = 2'b00;
                1: p = 2'b01;
                default: p = 2'b11;
            endcase
            run_and_compare("random", {wa, 2'($urandom_range(0, 3))}, t, p);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_cfg();
        apply_cfg();
        test_reset();
        test_all_off();
        test_napot();
        test_priority();
        test_lock();
        test_back_to_back();
        test_reset_mid_walk();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
